// File: rtl/logic_op_unit.sv
// Bitwise logic unit with pairwise/accumulate modes and a one-entry
// valid/ready output register.
module logic_op_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic [WIDTH-1:0] acc_prior;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      2'b00:   r = x | y;
      2'b01:   r = x & y;
      2'b10:   r = x ^ y;
      default: r = ~(x | y);
    endcase
    return r;
  endfunction

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign count     = count_q;

  // A clear on the accepting edge makes 0 the prior accumulator value.
  assign acc_prior = clr ? '0 : acc_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (accept) begin
      state_d = FULL;
      count_d = count_q + CNT_W'(1);
      if (mode) begin
        acc_d    = apply_op(op, acc_prior, a);
        result_d = acc_d;
      end else begin
        acc_d    = acc_prior;
        result_d = apply_op(op, a, b);
      end
    end else begin
      if (clr) acc_d = '0;
      if (state_q == FULL && out_ready) state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      result_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_logic_op_unit.sv
// Directed + random bench for logic_op_unit against a transaction-level model;
// a second instance with a 2-bit counter checks counter wrap.
module tb_logic_op_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, mode, clr;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       in_ready, out_valid, in_ready2, out_valid2;
  logic [7:0] result, result2;
  logic [7:0] count;
  logic [1:0] count2;

  int checks = 0;
  int fails  = 0;

  // reference model state
  int unsigned m_acc, m_res, m_cnt;
  bit          m_valid;

  always #5 clk = ~clk;

  logic_op_unit #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .mode(mode), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .count(count)
  );

  logic_op_unit #(.WIDTH(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .mode(mode), .clr(clr),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .count(count2)
  );

  function automatic int unsigned ref_op(input int unsigned o, input int unsigned x,
                                         input int unsigned y);
    int unsigned r;
    if (o == 0)      r = x | y;
    else if (o == 1) r = x & y;
    else if (o == 2) r = x ^ y;
    else             r = ~(x | y);
    return r % 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_res = 0; m_cnt = 0; m_valid = 0;
  endtask

  // One clock of stimulus: drive, check readiness, clock, check outputs.
  task automatic step(input bit iv, input int unsigned ia, input int unsigned ib,
                      input int unsigned iop, input bit imode, input bit iclr,
                      input bit ordy);
    bit rdy;
    in_valid = iv; a = 8'(ia); b = 8'(ib); op = 2'(iop);
    mode = imode; clr = iclr; out_ready = ordy;
    rdy = !m_valid || ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("in_ready_c2", 32'(in_ready2), 32'(rdy));
    if (iv && rdy) begin
      m_cnt++;
      m_valid = 1;
      if (imode) begin
        m_acc = ref_op(iop, iclr ? 0 : m_acc, ia % 256);
        m_res = m_acc;
      end else begin
        m_res = ref_op(iop, ia % 256, ib % 256);
        if (iclr) m_acc = 0;
      end
    end else begin
      if (iclr) m_acc = 0;
      if (m_valid && ordy) m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("result", 32'(result), m_res);
    chk("count", 32'(count), m_cnt % 256);
    chk("count_c2", 32'(count2), m_cnt % 4);
    in_valid = 1'b0; clr = 1'b0;
  endtask

  initial begin
    logic [7:0] exp33 [4];
    logic [7:0] exp34 [3];
    logic [7:0] a34   [3];
    exp33[0] = 8'hAF; exp33[1] = 8'h05; exp33[2] = 8'hAA; exp33[3] = 8'h50;
    exp34[0] = 8'h01; exp34[1] = 8'h02; exp34[2] = 8'hFD;
    a34[0]   = 8'h01; a34[1]   = 8'h03; a34[2]   = 8'hFF;

    rst = 1'b1; in_valid = 0; out_ready = 0; mode = 0; clr = 0; a = 0; b = 0; op = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;

    // pairwise ops on 0xA5 / 0x0F
    for (int k = 0; k < 4; k++) begin
      step(1, 'hA5, 'h0F, k, 0, 0, 1);
      chk("pairwise_const", 32'(result), 32'(exp33[k]));
      chk("pairwise_count", 32'(count), 32'(k + 1));
    end

    // accumulate XOR chain starting from a clear
    for (int k = 0; k < 3; k++) begin
      step(1, 32'(a34[k]), 'h00, 2, 1, k == 0, 1);
      chk("accum_const", 32'(result), 32'(exp34[k]));
    end

    // backpressure: hold 0x11 while downstream stalls
    step(1, 'h11, 'h00, 0, 0, 0, 1);
    chk("bp_first", 32'(result), 32'h11);
    for (int k = 0; k < 3; k++) begin
      step(1, 'h33, 'h00, 0, 0, 0, 0);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_result", 32'(result), 32'h11);
    end
    step(1, 'h22, 'h00, 0, 0, 0, 1);
    chk("bp_replace", 32'(result), 32'h22);
    chk("bp_valid", 32'(out_valid), 32'd1);

    // standalone clear of accumulator holding 0xF0
    step(1, 'hF0, 'h00, 0, 1, 1, 1);
    chk("clr_setup", 32'(result), 32'hF0);
    step(0, 'h00, 'h00, 0, 1, 1, 1);
    chk("clr_result_kept", 32'(result), 32'hF0);
    step(1, 'h01, 'h00, 0, 1, 0, 1);
    chk("clr_standalone", 32'(result), 32'h01);

    // async reset between edges while FULL
    step(1, 'h5A, 'h00, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(posedge clk);
    // release with in_valid held; accept on first edge must not be lost
    @(negedge clk) rst = 1'b0;
    step(1, 'h3C, 'hC3, 2, 0, 0, 1);
    chk("arst_release", 32'(result), 32'hFF);

    // counter wrap on the 2-bit instance (continues from count 1)
    for (int k = 0; k < 5; k++) step(1, k, 0, 0, 0, 0, 1);

    // random traffic
    for (int k = 0; k < 400; k++)
      step($urandom_range(3, 0) != 0, $urandom_range(255, 0), $urandom_range(255, 0),
           $urandom_range(3, 0), $urandom_range(1, 0) != 0, $urandom_range(7, 0) == 0,
           $urandom_range(2, 0) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
